// File: rtl/tanh_sched_pkg.sv
// tanh_sched_pkg
//   Shared definitions for the tanh activation scheduler:
//   default operand geometry, the tag carried alongside the tanh
//   pipeline, fixed-point helper constants and width helpers.
package tanh_sched_pkg;

   localparam int NUM_REQ_DEF    = 4;
   localparam int INT_WIDTH_DEF  = 16;
   localparam int FRAC_WIDTH_DEF = 16;

   // Operand/result width and requester-ID width at the default geometry.
   localparam int DATA_W = INT_WIDTH_DEF + FRAC_WIDTH_DEF;
   localparam int ID_W   = $clog2(NUM_REQ_DEF);

   // Tag ID field is sized for the largest supported requester count (8),
   // so one tag type serves every legal NUM_REQ.
   localparam int TAG_ID_W = 3;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

   // Q16.16 constants: 1.0 and 0.5.
   localparam logic [DATA_W-1:0] ONE_Q  = DATA_W'(1) << FRAC_WIDTH_DEF;
   localparam logic [DATA_W-1:0] HALF_Q = ONE_Q >> 1;

   function automatic int calc_data_w(input int int_w, input int frac_w);
      return int_w + frac_w;
   endfunction

   function automatic int calc_id_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tanh_scheduler_rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter. Searches from the requester after the last
//   winner, wrapping around, and grants the first active request.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   req         per-requester request vector
//   allow       grant enable (credit and enable already folded in)
//   grant       one-hot grant, combinational
//   grant_id    index of the granted requester
module rr_arbiter
   import tanh_sched_pkg::*;
#(
   parameter int N = 4,
   localparam int IW = calc_id_w(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          allow,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_id
);

   logic [IW-1:0] ptr_reg;

   always_comb begin
      int   idx;
      logic found;
      idx      = 0;
      found    = 1'b0;
      grant    = '0;
      grant_id = '0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr_reg) + k) % N;
         if (allow && !found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = IW'(idx);
         end
      end
   end

   // Pointer starts at N-1 so requester 0 has first priority after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= IW'(N - 1);
      end else if (|grant) begin
         ptr_reg <= grant_id;
      end
   end

endmodule

// File: rtl/tanh_scheduler.sv
// tanh_scheduler
//   Shares one fixed-latency, non-stalling tanh unit between NUM_REQ
//   requesters. Grants round-robin, registers the operand into the unit,
//   carries the requester ID through a tag pipe aligned with the unit,
//   and buffers results in a credit-protected response FIFO.
// Ports:
//   clk, rst_n              clock / asynchronous active-low reset
//   enable                  gate for new grants (in-flight work drains)
//   req_valid/req_data      per-requester operand requests
//   req_ready               one-hot grant (combinational)
//   tanh_in_valid/tanh_x    registered issue to the tanh unit
//   tanh_out_valid/tanh_y   result from the tanh unit
//   rsp_valid/id/data/ready response stream (valid/ready)
//   busy                    work in flight or FIFO non-empty
//   err_lost                sticky: an expected tanh result never arrived
module tanh_scheduler
   import tanh_sched_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int INT_WIDTH  = 16,
   parameter int FRAC_WIDTH = 16,
   parameter int TANH_LAT   = 4,
   parameter int RSP_DEPTH  = 8,
   localparam int DW  = calc_data_w(INT_WIDTH, FRAC_WIDTH),
   localparam int IDW = calc_id_w(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*DW-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic                  tanh_in_valid,
   output logic [DW-1:0]         tanh_x,
   input  logic                  tanh_out_valid,
   input  logic [DW-1:0]         tanh_y,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [DW-1:0]         rsp_data,
   input  logic                  rsp_ready,
   output logic                  busy,
   output logic                  err_lost
);

   localparam int PTR_W = $clog2(RSP_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [NUM_REQ-1:0]  grant;
   logic [IDW-1:0]      grant_id;
   logic [TAG_ID_W-1:0] grant_id_ext;
   logic                allow;
   logic                any_grant;
   int                  inflight;

   tag_t                issue_tag_reg;
   logic [DW-1:0]       issue_x_reg;
   tag_t                tag_pipe_reg [TANH_LAT];
   tag_t                tag_out;

   logic [DW-1:0]       mem_data [RSP_DEPTH];
   logic [IDW-1:0]      mem_id   [RSP_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]    fifo_count_reg, fifo_count_next;
   logic                push, pop, head_from_push;
   logic                rsp_valid_reg;
   logic [IDW-1:0]      rsp_id_reg;
   logic [DW-1:0]       rsp_data_reg;
   logic                err_lost_reg;

   // ---------------- credit and arbitration ----------------
   // Every accepted operation holds one credit from grant until its
   // response is popped (or its tag exits without a result).
   always_comb begin
      inflight = int'(issue_tag_reg.valid);
      for (int k = 0; k < TANH_LAT; k++) begin
         inflight = inflight + int'(tag_pipe_reg[k].valid);
      end
   end

   // Same-cycle pop is deliberately ignored: keeps the check off the
   // rsp_ready path at the cost of one occasional idle slot.
   assign allow = enable && ((int'(fifo_count_reg) + inflight) < RSP_DEPTH);

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req_valid),
      .allow    (allow),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign req_ready = grant;
   assign any_grant = |grant;

   always_comb begin
      grant_id_ext = '0;
      grant_id_ext[IDW-1:0] = grant_id;
   end

   // ---------------- issue register and tag pipe ----------------
   // The issue register is stage 0 of the tag path; the pipe behind it
   // has TANH_LAT stages so its last stage lines up with tanh_out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_tag_reg <= '0;
         issue_x_reg   <= '0;
         for (int k = 0; k < TANH_LAT; k++) begin
            tag_pipe_reg[k] <= '0;
         end
      end else begin
         issue_tag_reg.valid <= any_grant;
         issue_tag_reg.id    <= grant_id_ext;
         if (any_grant) begin
            issue_x_reg <= req_data[int'(grant_id)*DW +: DW];
         end
         tag_pipe_reg[0] <= issue_tag_reg;
         for (int k = 1; k < TANH_LAT; k++) begin
            tag_pipe_reg[k] <= tag_pipe_reg[k-1];
         end
      end
   end

   assign tanh_in_valid = issue_tag_reg.valid;
   assign tanh_x        = issue_x_reg;
   assign tag_out       = tag_pipe_reg[TANH_LAT-1];

   // Output without a tag is stale data from before a reset: dropped.
   assign push = tanh_out_valid && tag_out.valid;
   assign pop  = rsp_valid_reg && rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_lost_reg <= 1'b0;
      end else if (tag_out.valid && !tanh_out_valid) begin
         err_lost_reg <= 1'b1;
      end
   end

   // ---------------- response FIFO ----------------
   assign rd_ptr_next     = pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
   assign fifo_count_next = fifo_count_reg + CNT_W'(push) - CNT_W'(pop);
   // The entry written this edge becomes the head: bypass the array.
   assign head_from_push  = push && (wr_ptr_reg == rd_ptr_next);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr_reg] <= tanh_y;
         mem_id[wr_ptr_reg]   <= tag_out.id[IDW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fifo_count_reg <= '0;
         rsp_valid_reg  <= 1'b0;
         rsp_id_reg     <= '0;
         rsp_data_reg   <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         rd_ptr_reg     <= rd_ptr_next;
         fifo_count_reg <= fifo_count_next;
         rsp_valid_reg  <= (fifo_count_next != '0);
         if (fifo_count_next != '0) begin
            if (head_from_push) begin
               rsp_data_reg <= tanh_y;
               rsp_id_reg   <= tag_out.id[IDW-1:0];
            end else begin
               rsp_data_reg <= mem_data[rd_ptr_next];
               rsp_id_reg   <= mem_id[rd_ptr_next];
            end
         end
      end
   end

   assign rsp_valid = rsp_valid_reg;
   assign rsp_id    = rsp_id_reg;
   assign rsp_data  = rsp_data_reg;
   assign busy      = (inflight != 0) || (fifo_count_reg != '0);
   assign err_lost  = err_lost_reg;

   // Credit makes overflow impossible; a full push without a pop is a bug.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (fifo_count_reg == CNT_W'(RSP_DEPTH))));

   // Tags only ever carry IDs of real requesters.
   a_tag_id_range: assert property (@(posedge clk) disable iff (!rst_n)
      !tag_out.valid || (int'(tag_out.id) < NUM_REQ));

endmodule

// File: tb/tb_tanh_scheduler.sv
module tb_tanh_scheduler;
   import tanh_sched_pkg::*;

   localparam int NR  = 4;
   localparam int LAT = 4;
   localparam int DEP = 8;
   localparam int W   = 32;
   localparam int IW  = 2;

   logic              clk, rst_n, enable, rsp_ready;
   logic [NR-1:0]     req_valid, req_ready;
   logic [NR*W-1:0]   req_data;
   logic              tanh_in_valid, tanh_out_valid;
   logic [W-1:0]      tanh_x, tanh_y, rsp_data;
   logic              rsp_valid, busy, err_lost;
   logic [IW-1:0]     rsp_id;

   int checks = 0;
   int errors = 0;

   tanh_scheduler #(.NUM_REQ(NR), .INT_WIDTH(16), .FRAC_WIDTH(16),
                    .TANH_LAT(LAT), .RSP_DEPTH(DEP)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .tanh_in_valid(tanh_in_valid), .tanh_x(tanh_x),
      .tanh_out_valid(tanh_out_valid), .tanh_y(tanh_y),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_ready(rsp_ready), .busy(busy), .err_lost(err_lost));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Hard-tanh stand-in for the activation: saturates at +/-1.0.
   function automatic logic [W-1:0] tanh_f(input logic [W-1:0] x);
      logic signed [W-1:0] s;
      s = x;
      if (s > 32'sh0001_0000) return 32'h0001_0000;
      if (s < -32'sh0001_0000) return 32'hFFFF_0000;
      return x;
   endfunction

   // ---------------- tanh unit model (not reset, like the real one) ----------------
   logic         tu_v [LAT];
   logic [W-1:0] tu_x [LAT];
   int drop_req = 0;      // number of results the unit should swallow
   int tu_drop_done = 0;

   always @(posedge clk) begin
      for (int k = LAT-1; k > 0; k--) begin
         tu_v[k] <= tu_v[k-1];
         tu_x[k] <= tu_x[k-1];
      end
      tu_v[0] <= tanh_in_valid;
      tu_x[0] <= tanh_x;
      if (tu_v[LAT-2] && (drop_req > tu_drop_done)) begin
         tu_v[LAT-1] <= 1'b0;
         tu_drop_done <= tu_drop_done + 1;
      end
   end
   assign tanh_out_valid = tu_v[LAT-1];
   assign tanh_y         = tanh_f(tu_x[LAT-1]);

   // ---------------- behavioural reference model + per-cycle compare ----------------
   // Each accepted operation is an entry that becomes visible LAT+2 sample
   // points after the one where it was accepted; entries leave in order.
   typedef struct {
      logic [IW-1:0] id;
      logic [W-1:0]  y;
      int            avail;
      bit            lost;
   } ent_t;

   ent_t         q[$];
   int           ptr_m = NR-1;
   bit           err_m = 0;
   int           cyc = 0;
   bit           last_g = 0;
   logic [W-1:0] last_x = '0;
   int           m_drop_done = 0;
   int           dut_pops = 0;

   always @(negedge clk) begin : model
      int g;
      int idx;
      logic [NR-1:0] exp_ready;
      bit exp_rv;
      ent_t e;
      if (!rst_n) begin
         q.delete();
         ptr_m  = NR-1;
         err_m  = 0;
         last_g = 0;
         chk("rst_tanh_in_valid", tanh_in_valid, 0);
         chk("rst_tanh_x", tanh_x, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_id", rsp_id, 0);
         chk("rst_rsp_data", rsp_data, 0);
         chk("rst_busy", busy, 0);
         chk("rst_err_lost", err_lost, 0);
      end else begin
         g = -1;
         if (enable && q.size() < DEP) begin
            for (int k = 1; k <= NR; k++) begin
               idx = (ptr_m + k) % NR;
               if (g < 0 && req_valid[idx]) g = idx;
            end
         end
         exp_ready = '0;
         if (g >= 0) exp_ready[g] = 1'b1;
         chk("req_ready", req_ready, exp_ready);
         chk("tanh_in_valid", tanh_in_valid, last_g);
         if (last_g) chk("tanh_x", tanh_x, last_x);
         exp_rv = (q.size() > 0) && !q[0].lost && (q[0].avail <= cyc);
         chk("rsp_valid", rsp_valid, exp_rv);
         if (exp_rv) begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_data", rsp_data, q[0].y);
         end
         chk("busy", busy, q.size() != 0);
         chk("err_lost", err_lost, err_m);

         if (exp_rv && rsp_ready) void'(q.pop_front());
         for (int k = q.size()-1; k >= 0; k--) begin
            if (q[k].lost && q[k].avail == cyc + 1) begin
               q.delete(k);
               err_m = 1;
            end
         end
         if (g >= 0) begin
            e.id    = IW'(g);
            e.y     = tanh_f(req_data[g*W +: W]);
            e.avail = cyc + LAT + 2;
            e.lost  = (drop_req > m_drop_done);
            if (e.lost) m_drop_done++;
            q.push_back(e);
            ptr_m  = g;
            last_g = 1;
            last_x = req_data[g*W +: W];
         end else begin
            last_g = 0;
         end
         if (rsp_valid && rsp_ready) dut_pops++;
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk); @(negedge clk); #1 rst_n = 1'b1;
      tick();
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (busy && c < 100) begin tick(); c++; end
      chk("drain_busy", busy, 0);
   endtask

   function automatic int oh2id(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) if (v[i]) return i;
      return -1;
   endfunction

   initial begin : stim
      int n, n2, edges, gaps, got, pops0;
      int gids[$];
      int rids[$];
      bit hs;
      rst_n = 1'b0; enable = 1'b0; rsp_ready = 1'b0;
      req_valid = '0; req_data = '0;

      chk("model_tanh_half", tanh_f(32'h0000_8000), 32'h0000_8000);
      chk("model_tanh_sat_pos", tanh_f(32'h0003_0000), 32'h0001_0000);
      chk("model_tanh_sat_neg", tanh_f(32'hFFFD_0000), 32'hFFFF_0000);

      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      enable = 1'b1; rsp_ready = 1'b1;

      // single request: 0.5 from requester 0
      req_data[0*W +: W] = HALF_Q;
      req_valid = 4'b0001;
      hs = 0;
      for (int c = 0; c < 20 && !hs; c++) begin
         @(negedge clk);
         if (req_ready[0]) hs = 1; else tick();
      end
      chk("single_handshake", hs, 1);
      tick();
      req_valid = '0;
      edges = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); edges++;
         @(negedge clk);
         if (rsp_valid) break;
      end
      chk("single_latency", edges, 5);
      chk("single_rsp_id", rsp_id, 0);
      chk("single_rsp_data", rsp_data, 32'h0000_8000);
      $display("single: latency %0d edges, id %0d data 0x%08h", edges, rsp_id, rsp_data);
      drain();

      // all four requesters for 12 cycles
      do_reset();
      for (int i = 0; i < NR; i++) req_data[i*W +: W] = 32'h0000_1000 * (i + 1);
      req_valid = 4'hF;
      fork
         begin
            for (int c = 0; c < 12; c++) begin
               @(negedge clk);
               gids.push_back(oh2id(req_ready));
               tick();
            end
            req_valid = '0;
         end
         begin
            got = 0; gaps = 0;
            for (int c = 0; c < 60 && got < 12; c++) begin
               @(negedge clk);
               if (rsp_valid) begin rids.push_back(int'(rsp_id)); got++; end
               else if (got > 0) gaps++;
            end
         end
      join
      for (int k = 0; k < 12; k++) begin
         chk("rr_grant_order", gids[k], k % 4);
         chk("rr_rsp_order", (k < rids.size()) ? rids[k] : -1, k % 4);
         $display("rr: grant %0d -> id %0d, response %0d -> id %0d",
                  k, gids[k], k, (k < rids.size()) ? rids[k] : -1);
      end
      chk("rr_rsp_count", got, 12);
      chk("rr_gaps", gaps, 0);
      drain();

      // backpressure: credit must cap accepted work at the FIFO depth
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); if (req_ready != '0) n++;
         tick();
      end
      chk("bp_accepted", n, 8);
      $display("backpressure: %0d accepted with rsp_ready low", n);
      rsp_ready = 1'b1;
      n2 = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk); if (req_ready != '0) n2++;
         tick();
      end
      chk("bp_resume", n2 != 0, 1);
      req_valid = '0;
      drain();
      chk("bp_err_lost", err_lost, 0);

      // enable dropped after 3 grants
      pops0 = dut_pops;
      req_valid = 4'hF;
      n = 0;
      for (int c = 0; c < 20 && n < 3; c++) begin
         @(negedge clk); if (req_ready != '0) n++;
         tick();
      end
      req_valid = '0;
      tick(); tick();
      enable = 1'b0;
      req_valid = 4'hF;
      n2 = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); if (req_ready != '0) n2++;
         tick();
      end
      chk("en_no_grants", n2, 0);
      chk("en_pops", dut_pops - pops0, 3);
      chk("en_busy_low", busy, 0);
      $display("enable low: %0d grants, %0d responses", n2, dut_pops - pops0);
      req_valid = '0;
      enable = 1'b1;

      // reset with 3 operations inside the tanh unit
      req_valid = 4'b0001;
      n = 0;
      for (int c = 0; c < 20 && n < 3; c++) begin
         @(negedge clk); if (req_ready[0]) n++;
         tick();
      end
      req_valid = '0;
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk); #1 rst_n = 1'b1;
      n = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); if (rsp_valid) n++;
      end
      chk("stale_no_rsp", n, 0);
      chk("stale_err_lost", err_lost, 0);
      chk("stale_busy", busy, 0);
      $display("stale after reset: %0d responses, err_lost %0d", n, err_lost);

      // tanh unit swallows one result
      tick();
      drop_req++;
      req_valid = 4'b0001;
      hs = 0;
      for (int c = 0; c < 20 && !hs; c++) begin
         @(negedge clk);
         if (req_ready[0]) hs = 1; else tick();
      end
      chk("drop_handshake", hs, 1);
      tick();
      req_valid = '0;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk); @(negedge clk);
         if (e == 4) chk("drop_err_before", err_lost, 0);
         if (e == 5) chk("drop_err_rise", err_lost, 1);
         if (e == 8) chk("drop_err_sticky", err_lost, 1);
      end
      $display("drop: err_lost %0d", err_lost);
      do_reset();
      chk("drop_err_cleared", err_lost, 0);

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         req_valid = NR'($urandom);
         for (int i = 0; i < NR; i++) req_data[i*W +: W] = $urandom;
         rsp_ready = ($urandom_range(3) != 0);
         enable    = ($urandom_range(15) != 0);
         tick();
      end
      req_valid = '0; enable = 1'b1; rsp_ready = 1'b1;
      drain();
      $display("random: %0d responses total", dut_pops);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
